// File: rtl/data_mem_banked_if.sv
// Bus between the CPU data port and the banked data memory.
// The master drives the requests, and the slave returns the read data and the status.
interface data_mem_banked_if #(
    parameter int ABITS = 32,
    parameter int DBITS = 32
);
    localparam int NB = DBITS / 8;

    logic             en;
    logic             we;
    logic [NB-1:0]    be;
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] din;
    logic [DBITS-1:0] dout;
    logic             dout_valid;
    logic             err;
    logic             busy;

    modport master (
        output en, we, be, addr, din,
        input  dout, dout_valid, err, busy
    );

    modport slave (
        input  en, we, be, addr, din,
        output dout, dout_valid, err, busy
    );
endinterface

// File: rtl/data_mem_banked.sv
// Synchronous word memory with byte-lane writes, access checking and a zeroing sweep after reset.
// The read latency is 1 cycle, or 2 cycles when OUT_REG=1.
module data_mem_banked #(
    parameter int ABITS   = 32,
    parameter int DBITS   = 32,
    parameter int DEPTH   = 1024,
    parameter int OUT_REG = 0
) (
    input logic clk,
    input logic rst,
    data_mem_banked_if.slave bus
);
    localparam int NB = DBITS / 8;
    localparam int OB = $clog2(NB);
    localparam int WB = $clog2(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state;
    logic [WB-1:0]    cnt;
    logic             busy;
    logic [DBITS-1:0] mem [DEPTH];

    logic [DBITS-1:0] s1_data;
    logic             s1_valid;
    logic             s1_err;
    logic [DBITS-1:0] dout_r;
    logic             valid_r;
    logic             err_r;

    logic          aligned;
    logic          in_range;
    logic          legal;
    logic          idle;
    logic          rd_ok;
    logic          wr_ok;
    logic          req_bad;
    logic [WB-1:0] idx;

    // The masks avoid slicing addr when there is only one byte lane (OB=0).
    assign aligned  = (bus.addr & ABITS'(NB - 1)) == '0;
    assign in_range = (bus.addr >> (OB + WB)) == '0;
    assign legal    = aligned && in_range;
    assign idle     = (state == IDLE);
    assign idx      = bus.addr[OB+WB-1:OB];
    assign rd_ok    = idle && !bus.we && bus.en && legal;
    assign wr_ok    = idle && bus.we && legal;
    assign req_bad  = idle && (bus.we || bus.en) && !legal;

    // The storage array is never reset, because the sweep rewrites every word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.be[i]) mem[idx][8*i +: 8] <= bus.din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            dout_r   <= '0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
                if (cnt == WB'(DEPTH - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
            s1_valid <= rd_ok;
            s1_err   <= req_bad;
            if (rd_ok) s1_data <= mem[idx];
            // This second stage only exists to feed dout when OUT_REG=1.
            valid_r <= s1_valid;
            err_r   <= s1_err;
            if (s1_valid) dout_r <= s1_data;
        end
    end

    assign bus.dout       = (OUT_REG != 0) ? dout_r  : s1_data;
    assign bus.dout_valid = (OUT_REG != 0) ? valid_r : s1_valid;
    assign bus.err        = (OUT_REG != 0) ? err_r   : s1_err;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_data_mem_banked.sv
// Drives the same request stream into the latency-1 and latency-2 variants of the memory.
// Both variants are compared against an event-level reference model.
module tb_data_mem_banked;
    localparam int ABITS = 32;
    localparam int DBITS = 32;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        en_s;
    logic        we_s;
    logic [3:0]  be_s;
    logic [31:0] addr_s;
    logic [31:0] din_s;

    data_mem_banked_if #(.ABITS(ABITS), .DBITS(DBITS)) if0 ();
    data_mem_banked_if #(.ABITS(ABITS), .DBITS(DBITS)) if1 ();

    assign if0.en = en_s;
    assign if0.we = we_s;
    assign if0.be = be_s;
    assign if0.addr = addr_s;
    assign if0.din = din_s;
    assign if1.en = en_s;
    assign if1.we = we_s;
    assign if1.be = be_s;
    assign if1.addr = addr_s;
    assign if1.din = din_s;

    data_mem_banked #(.ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    data_mem_banked #(.ABITS(ABITS), .DBITS(DBITS), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks = 0;
    int bad_checks = 0;

    logic [31:0] model_mem [DEPTH];
    int          sweep_left = 0;
    bit          prev_rd = 0;
    bit          prev_er = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_dout0 = '0;
    logic [31:0] exp_dout1 = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s at t=%0t: got %h want %h", tag, $time, observed, expected);
        end
    endtask

    // One clock cycle: present the inputs, advance the model by one edge, then compare.
    task automatic applyStimulus(input bit r, input bit e, input bit w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
        bit          cur_rd = 0;
        bit          cur_er = 0;
        logic [31:0] cur_data = '0;
        bit          exp_v0, exp_e0, exp_v1, exp_e1;
        int          word;
        rst = r; en_s = e; we_s = w; be_s = b; addr_s = a; din_s = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (w || e) begin
            if ((a % 4 != 0) || (a >= DEPTH * 4)) begin
                cur_er = 1;
            end else begin
                word = int'(a / 4);
                if (w) begin
                    for (int i = 0; i < 4; i++)
                        if (b[i]) model_mem[word][8*i +: 8] = d[8*i +: 8];
                end else begin
                    cur_rd = 1;
                    cur_data = model_mem[word];
                end
            end
        end
        if (r) begin
            exp_v0 = 0; exp_e0 = 0; exp_v1 = 0; exp_e1 = 0;
            exp_dout0 = '0; exp_dout1 = '0;
            prev_rd = 0; prev_er = 0;
        end else begin
            exp_v0 = cur_rd; exp_e0 = cur_er;
            if (cur_rd) exp_dout0 = cur_data;
            exp_v1 = prev_rd; exp_e1 = prev_er;
            if (prev_rd) exp_dout1 = prev_data;
            prev_rd = cur_rd; prev_er = cur_er; prev_data = cur_data;
        end
        #1;
        checkOutput("busy_lat1", 32'(if0.busy), 32'(sweep_left > 0));
        checkOutput("busy_lat2", 32'(if1.busy), 32'(sweep_left > 0));
        checkOutput("valid_lat1", 32'(if0.dout_valid), 32'(exp_v0));
        checkOutput("err_lat1", 32'(if0.err), 32'(exp_e0));
        checkOutput("dout_lat1", if0.dout, exp_dout0);
        checkOutput("valid_lat2", 32'(if1.dout_valid), 32'(exp_v1));
        checkOutput("err_lat2", 32'(if1.err), 32'(exp_e1));
        checkOutput("dout_lat2", if1.dout, exp_dout1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; en_s = 1'b0; we_s = 1'b0; be_s = '0; addr_s = '0; din_s = '0;
        @(negedge clk);

        $display("[TB] reset and sweep, with dropped writes");
        applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 4'hF, 32'(i * 4), 32'hFFFF_FFFF);
        applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 4'h0, 32'h4, 32'h0);
        applyStimulus(0, 1, 0, 4'h0, 32'((DEPTH - 1) * 4), 32'h0);
        idleCycles(2);

        $display("[TB] basic write/read and byte lanes");
        applyStimulus(0, 0, 1, 4'hF, 32'h0, 32'h0000_F123);
        applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 4'hF, 32'h8, 32'h1122_3344);
        applyStimulus(0, 1, 1, 4'b0101, 32'h8, 32'hAABB_CCDD);
        applyStimulus(0, 1, 0, 4'h0, 32'h8, 32'h0);
        applyStimulus(0, 0, 1, 4'h0, 32'h4, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 0, 4'h0, 32'h4, 32'h0);
        idleCycles(2);

        $display("[TB] illegal accesses");
        applyStimulus(0, 1, 0, 4'h0, 32'h2, 32'h0);
        idleCycles(1);
        applyStimulus(0, 0, 1, 4'hF, 32'(DEPTH * 4), 32'h5555_5555);
        applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0);
        idleCycles(2);

        $display("[TB] back-to-back reads");
        applyStimulus(0, 1, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(0, 1, 0, 4'h0, 32'h4, 32'h0);
        applyStimulus(0, 1, 0, 4'h0, 32'h8, 32'h0);
        idleCycles(2);

        $display("[TB] reset mid-sweep and during an in-flight read");
        applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0);
        idleCycles(DEPTH / 2);
        applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0);
        idleCycles(DEPTH);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 4'h0, 32'(i * 4), 32'h0);
        applyStimulus(0, 0, 1, 4'hF, 32'hC, 32'h1234_5678);
        applyStimulus(0, 1, 0, 4'h0, 32'hC, 32'h0);
        applyStimulus(1, 0, 0, 4'h0, 32'h0, 32'h0);
        idleCycles(DEPTH + 1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            if (sel < 7) a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel < 9) a = 32'($urandom_range(0, DEPTH * 4 - 1));
            else a = $urandom;
            applyStimulus($urandom_range(0, 149) == 0, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                          4'($urandom), a, $urandom);
        end
        idleCycles(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 4'h0, 32'(i * 4), 32'h0);
        idleCycles(2);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
